regs_arbiter: RTL
=================

// Module: regs_arbiter
// PURPOSE
//  N-client arbiter in front of the shared TCPC register file; successor to the fixed 4-client mux.
//  Registered 4-phase handshake per client, fixed-priority or round-robin mode.
//  Transaction locked until ACK or timeout; per-client error flag on timeout.
//  Sits between Tx/Rx/HReset/tcpm (and future) clients and the register block.
// PARAMETERS
//  N_CLIENTS  4   number of clients; client 0 = highest fixed priority (tcpm slot)
//  ADDR_W     8   register address width
//  DATA_W     8   register data width
//  RR_MODE    0   0 = fixed priority (lowest index wins), 1 = round-robin
//  TIMEOUT    15  max cycles in BUSY without ACK before abort (>=1)
// PORTS
//  CLK          in   1                 clock, rising edge
//  RESET_N      in   1                 async reset, active low
//  REQ          in   N_CLIENTS         per-client request, held until its ACK_OUT seen
//  RNW_IN       in   N_CLIENTS         per-client 1=read 0=write
//  ADDR_IN      in   N_CLIENTS*ADDR_W  packed addresses, client i at [i*ADDR_W +: ADDR_W]
//  WR_DATA_IN   in   N_CLIENTS*DATA_W  packed write data
//  ACK_OUT      out  N_CLIENTS         per-client completion, held until REQ[i] drops
//  ERR_OUT      out  N_CLIENTS         per-client timeout flag, valid with ACK_OUT
//  RD_DATA_OUT  out  N_CLIENTS*DATA_W  packed read data, valid with ACK_OUT
//  GRANT        out  N_CLIENTS         one-hot owner, 0 in IDLE
//  REQUEST      out  1                 request to register block
//  RNW          out  1                 read/not-write to register block
//  ADDR         out  ADDR_W            address to register block
//  WR_DATA      out  DATA_W            write data to register block
//  ACK          in   1                 register block completion (1-cycle pulse or level)
//  RD_DATA      in   DATA_W            register read data, sampled when ACK=1
// BEHAVIOUR
//  Reset (async, RESET_N=0): all outputs 0, state IDLE, RR pointer 0, timeout counter 0.
//  States: IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: if |REQ, pick winner g, latch RNW_IN[g]/ADDR_IN[g]/WR_DATA_IN[g], GRANT=onehot(g) -> BUSY.
//   Fixed mode: lowest index with REQ=1. RR mode: first REQ at or above pointer, wrapping at N_CLIENTS-1->0.
//  BUSY: REQUEST=1, RNW/ADDR/WR_DATA from latched copy, constant for the whole transaction.
//   Latency: REQ rises in cycle t (IDLE) -> REQUEST=1 in cycle t+1.
//   ACK=1 -> RD_DATA_OUT[g]=RD_DATA if read, else 0; ACK_OUT[g]=1, ERR_OUT[g]=0 next cycle -> DONE.
//   Counter increments each BUSY cycle without ACK; reaching TIMEOUT -> ACK_OUT[g]=1, ERR_OUT[g]=1,
//   RD_DATA_OUT[g]=0 -> DONE. ACK in the same cycle as counter==TIMEOUT: ACK wins, no error.
//   REQ[g] dropping in BUSY: ignored, transaction completes normally.
//  DONE: REQUEST=0, bus outputs 0; ACK_OUT/ERR_OUT/RD_DATA_OUT[g] held while REQ[g]=1.
//   REQ[g]=0 -> clear ACK_OUT/ERR_OUT/RD_DATA_OUT[g], GRANT=0, counter=0, RR pointer=(g+1) mod N -> IDLE.
//   No back-to-back grant: at least one IDLE cycle between transactions.
//  Other clients' REQ changes never affect the active transaction; non-granted ACK_OUT/ERR_OUT/RD_DATA_OUT stay 0.
//  ACK outside BUSY: ignored.
//  Counter width $clog2(TIMEOUT+1); pointer width $clog2(N_CLIENTS) (min 1).
// STRUCTURE
//  regs_arb_pkg: state enum (IDLE/BUSY/DONE), helper function onehot(idx), default widths.
//  Sub-module rr_picker (N_CLIENTS, RR_MODE): combinational pick of winner index from REQ + pointer.
//  Top: FSM, latch registers, timeout counter, per-client response registers.
// TESTING
//  1 Single read: REQ[2]=1, RNW_IN[2]=1, ADDR_IN[2]=8'h10; ACK+RD_DATA=8'hA5 3 cycles later
//    -> REQUEST=1 at t+1, ADDR=8'h10, ACK_OUT[2]=1, RD_DATA_OUT[2]=8'hA5, ERR_OUT[2]=0.
//  2 Fixed priority: RR_MODE=0, REQ=4'b1110 -> grants 1,2,3 in order, each after prior REQ drops.
//  3 Round-robin: RR_MODE=1, REQ=4'b1111 held, each REQ re-raised after its ACK -> grant order 0,1,2,3,0.
//  4 Timeout: REQ[0] write, ACK never -> after 15 BUSY cycles ACK_OUT[0]=1, ERR_OUT[0]=1; next REQ proceeds.
//  5 Async reset mid-BUSY: RESET_N=0 -> REQUEST, GRANT, ACK_OUT=0 immediately; after release, REQ[3] wins alone.
//  6 ACK on timeout cycle + REQ[g] drop in BUSY -> ERR_OUT=0, transaction completes, DONE exits in 1 cycle.

Source files
------------

// File: rtl/regs_arb_pkg.sv
// Shared types, default geometry and helpers for the TCPC register-file arbiter.
package regs_arb_pkg;

  localparam int unsigned DEF_N_CLIENTS = 4;
  localparam int unsigned DEF_ADDR_W    = 8;
  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_TIMEOUT   = 15;
  localparam int unsigned MAX_CLIENTS   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  function automatic logic [MAX_CLIENTS-1:0] onehot(input int unsigned idx);
    onehot = MAX_CLIENTS'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection: lowest requesting index, or first requester
// at/after the round-robin pointer with wrap-around.
module rr_picker #(
  parameter int unsigned N_CLIENTS = 4,
  parameter int unsigned RR_MODE   = 0,
  parameter int unsigned PTR_W     = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
  input  logic [N_CLIENTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic                 valid,
  output logic [PTR_W-1:0]     idx
);

  int unsigned      cand;
  logic [PTR_W-1:0] cand_idx;
  logic             found;

  always_comb begin
    valid    = |req;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      cand = (RR_MODE != 0) ? (32'(ptr) + i) : i;
      if (cand >= N_CLIENTS) cand = cand - N_CLIENTS;
      cand_idx = PTR_W'(cand);
      if (!found && req[cand_idx]) begin
        idx   = cand_idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regs_arbiter.sv
// N-client arbiter in front of the shared TCPC register file: one locked
// transaction at a time, 4-phase handshake per client, timeout abort with error.
module regs_arbiter
  import regs_arb_pkg::*;
#(
  parameter int unsigned N_CLIENTS = DEF_N_CLIENTS,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned RR_MODE   = 0,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic [N_CLIENTS-1:0]        REQ,
  input  logic [N_CLIENTS-1:0]        RNW_IN,
  input  logic [N_CLIENTS*ADDR_W-1:0] ADDR_IN,
  input  logic [N_CLIENTS*DATA_W-1:0] WR_DATA_IN,
  output logic [N_CLIENTS-1:0]        ACK_OUT,
  output logic [N_CLIENTS-1:0]        ERR_OUT,
  output logic [N_CLIENTS*DATA_W-1:0] RD_DATA_OUT,
  output logic [N_CLIENTS-1:0]        GRANT,
  output logic                       REQUEST,
  output logic                       RNW,
  output logic [ADDR_W-1:0]          ADDR,
  output logic [DATA_W-1:0]          WR_DATA,
  input  logic                       ACK,
  input  logic [DATA_W-1:0]          RD_DATA
);

  localparam int unsigned PTR_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t             state;
  logic [PTR_W-1:0]       ptr;
  logic [PTR_W-1:0]       owner;
  logic [CNT_W-1:0]       cnt;
  logic                   lat_rnw;
  logic [ADDR_W-1:0]      lat_addr;
  logic [DATA_W-1:0]      lat_wdata;
  logic                   pick_valid;
  logic [PTR_W-1:0]       pick_idx;
  logic [N_CLIENTS-1:0]   pick_onehot;

  rr_picker #(
    .N_CLIENTS (N_CLIENTS),
    .RR_MODE   (RR_MODE),
    .PTR_W     (PTR_W)
  ) u_picker (
    .req   (REQ),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign pick_onehot = N_CLIENTS'(onehot(32'(pick_idx)));

  // Bus side is a pure decode of state so reset clears it without a clock.
  assign REQUEST = (state == ST_BUSY);
  assign RNW     = REQUEST & lat_rnw;
  assign ADDR    = REQUEST ? lat_addr  : '0;
  assign WR_DATA = REQUEST ? lat_wdata : '0;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      owner       <= '0;
      cnt         <= '0;
      lat_rnw     <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      GRANT       <= '0;
      ACK_OUT     <= '0;
      ERR_OUT     <= '0;
      RD_DATA_OUT <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            owner     <= pick_idx;
            lat_rnw   <= RNW_IN[pick_idx];
            lat_addr  <= ADDR_IN[pick_idx*ADDR_W +: ADDR_W];
            lat_wdata <= WR_DATA_IN[pick_idx*DATA_W +: DATA_W];
            GRANT     <= pick_onehot;
            cnt       <= '0;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // ACK is checked first so an ACK on the final allowed cycle still succeeds.
          if (ACK) begin
            ACK_OUT[owner]                        <= 1'b1;
            ERR_OUT[owner]                        <= 1'b0;
            RD_DATA_OUT[owner*DATA_W +: DATA_W]   <= lat_rnw ? RD_DATA : '0;
            state                                 <= ST_DONE;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            ACK_OUT[owner]                        <= 1'b1;
            ERR_OUT[owner]                        <= 1'b1;
            RD_DATA_OUT[owner*DATA_W +: DATA_W]   <= '0;
            state                                 <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (!REQ[owner]) begin
            ACK_OUT     <= '0;
            ERR_OUT     <= '0;
            RD_DATA_OUT <= '0;
            GRANT       <= '0;
            cnt         <= '0;
            ptr         <= (owner == PTR_W'(N_CLIENTS - 1)) ? '0 : owner + 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
